// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit counter must reach W-1; W >= 2 keeps this at least one bit wide.
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Load/result bundle for serial_adder; ovf exists only with SERIAL_ADDER_OVF_EN.
interface serial_adder_if #(
  parameter int W = 4
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  modport master (
    output start, a, b, cin,
    input  busy, done, s, cout
`ifdef SERIAL_ADDER_OVF_EN
    , ovf
`endif
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, s, cout
`ifdef SERIAL_ADDER_OVF_EN
    , ovf
`endif
  );
endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// Single combinational full-adder cell shared by every bit position of the serial adder.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);
  assign sum = x ^ y ^ ci;
  assign co  = (x & y) | (x & ci) | (y & ci);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder: parallel load, LSB-first add, parallel result + done strobe.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = 4
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam int CW = cnt_w(W);

  state_e          state_q, state_d;
  logic            load;
  logic            last;
  logic [W-1:0]    opa_q, opb_q, res_q, s_q;
  logic            carry_q, cout_q;
  logic [CW-1:0]   cnt_q;
  logic            sum_bit, co;
  logic [W-1:0]    res_next;
`ifdef SERIAL_ADDER_OVF_EN
  logic            ovf_q;
`endif

  full_adder_cell u_fa (
    .x   (opa_q[0]),
    .y   (opb_q[0]),
    .ci  (carry_q),
    .sum (sum_bit),
    .co  (co)
  );

  assign last     = (state_q == SHIFT) && (cnt_q == CW'(W - 1));
  assign res_next = {sum_bit, res_q[W-1:1]};

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        // Back-to-back start is accepted here so no IDLE bubble is needed.
        if (bus.start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else if (load) begin
      opa_q   <= bus.a;
      opb_q   <= bus.b;
      res_q   <= '0;
      carry_q <= bus.cin;
      cnt_q   <= '0;
    end else if (state_q == SHIFT) begin
      opa_q   <= opa_q >> 1;
      opb_q   <= opb_q >> 1;
      res_q   <= res_next;
      carry_q <= co;
      cnt_q   <= cnt_q + 1'b1;
      if (last) begin
        s_q    <= res_next;
        cout_q <= co;
`ifdef SERIAL_ADDER_OVF_EN
        // carry_q here is the carry into the MSB cell.
        ovf_q  <= carry_q ^ co;
`endif
      end
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (W=4): directed vectors, monitor pops on each done pulse.
module tb_serial_adder;
  localparam int W = 4;

  logic clk;
  logic rst;

  serial_adder_if #(.W(W)) bus ();

  serial_adder #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] s, input logic cout, input logic ovf);
    exp_t e;
    e.s = s; e.cout = cout; e.ovf = ovf;
    q.push_back(e);
  endtask

  // Called just after a rising edge; start is sampled on the following edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int nbusy);
    bit found;
    found = 0;
    nbusy = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.done) found = 1;
      else if (bus.busy) nbusy++;
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done, expected done within 20 cycles", name);
    end
  endtask

  task automatic realign();
    @(posedge clk); #1;
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      done_cnt++;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_done: got done with s=%0d, expected no done", bus.s);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_s", 32'(bus.s), 32'(e.s));
        chk("sb_cout", 32'(bus.cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
        chk("sb_ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish before 100us");
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    int d0;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_s", 32'(bus.s), 0);
    chk("rst_cout", 32'(bus.cout), 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", 32'(bus.ovf), 0);
`endif
    rst = 1'b0;
    realign();

    // 5+3 = 8: latency and busy length
    push(4'd8, 1'b0, 1'b1);
    issue(4'd5, 4'd3, 1'b0);
    wait_done("t1", nb);
    chk("t1_busy_cycles", 32'(nb), 4);
    realign();

    // Carry-out cases
    push(4'd0, 1'b1, 1'b0);
    issue(4'd15, 4'd1, 1'b0);
    wait_done("t2a", nb);
    realign();
    push(4'd0, 1'b1, 1'b0);
    issue(4'd9, 4'd6, 1'b1);
    wait_done("t2b", nb);
    realign();

    // start during SHIFT is ignored
    d0 = done_cnt;
    push(4'd4, 1'b0, 1'b0);
    issue(4'd2, 4'd2, 1'b0);
    issue(4'd7, 4'd7, 1'b0);
    wait_done("t3", nb);
    repeat (6) @(posedge clk);
    #1;
    chk("t3_done_count", 32'(done_cnt - d0), 1);
    chk("t3_idle_busy", 32'(bus.busy), 0);

    // start held through DONE: back-to-back accept
    push(4'd2, 1'b0, 1'b0);
    push(4'd7, 1'b0, 1'b0);
    bus.a = 4'd1; bus.b = 4'd1; bus.cin = 1'b0; bus.start = 1'b1;
    wait_done("t4a", nb);
    bus.a = 4'd3; bus.b = 4'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("t4_b2b_busy", 32'(bus.busy), 1);
    wait_done("t4b", nb);
    chk("t4_b2b_busy_rest", 32'(nb), 3);
    realign();

    // Asynchronous reset two cycles into SHIFT
    issue(4'd5, 4'd6, 1'b0);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_done", 32'(bus.done), 0);
    chk("t5_s", 32'(bus.s), 0);
    chk("t5_cout", 32'(bus.cout), 0);
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (8) @(posedge clk);
    #1;
    chk("t5_no_done", 32'(done_cnt - d0), 0);
    push(4'd14, 1'b0, 1'b1);
    issue(4'd6, 4'd7, 1'b1);
    wait_done("t5_fresh", nb);
    chk("t5_fresh_busy", 32'(nb), 4);
    realign();

    // Signed-overflow vectors (s/cout checked in every build)
    push(4'd8, 1'b0, 1'b1);
    issue(4'd7, 4'd1, 1'b0);
    wait_done("t6a", nb);
    realign();
    push(4'd0, 1'b1, 1'b1);
    issue(4'd8, 4'd8, 1'b0);
    wait_done("t6b", nb);
    realign();
    push(4'd5, 1'b0, 1'b0);
    issue(4'd3, 4'd2, 1'b0);
    wait_done("t6c", nb);
    realign();

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial two's-complement adder; the additive counterpart of the team's ripple-borrow subtractor.
- Operands are loaded in parallel, then added LSB-first at one bit per clock through a single full-adder cell and a carry flip-flop.
- Used where area matters more than latency; the result is presented in parallel with a one-cycle done strobe.

Parameters:
- W, 4, operand/result width in bits; legal range W >= 2.

Ports:
- clk  in  1  single system clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  load request; sampled only when not busy
- a  in  W  augend, captured on accepted start
- b  in  W  addend, captured on accepted start
- cin  in  1  carry-in, captured on accepted start
- busy  out  1  high while a serial addition is in progress
- done  out  1  one-cycle pulse: s/cout valid
- s  out  W  sum, registered; holds until the next completion
- cout  out  1  carry-out of MSB, registered; holds with s

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - State = IDLE.
  - busy = 0, done = 0, s = 0, cout = 0.
  - Internal shift registers, carry flip-flop and bit counter = 0.
- States: IDLE, SHIFT, DONE (2-bit encoding).
- IDLE:
  - If start=1 at edge k: capture a, b into operand shift registers and cin into the carry flip-flop; clear counter; go to SHIFT.
  - busy=1 from the cycle after edge k.
- SHIFT:
  - Each edge: sum bit = opA[0]^opB[0]^carry.
  - The sum bit is shifted into the result shift register from the MSB side.
  - Carry <= majority(opA[0], opB[0], carry).
  - opA and opB shift right by 1; counter increments.
  - After W SHIFT edges (counter reaches W-1 on the last edge), go to DONE.
  - On that same edge, load s from the completed result and cout from the final carry.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next state is IDLE, or SHIFT if start=1 (a back-to-back start is accepted in DONE).
- Latency: start accepted at edge k; s/cout updated at edge k+W; done high in cycle k+W .. k+W+1.
- start while in SHIFT is ignored; it is neither queued nor corrupting.
- a, b, cin changes after capture have no effect.
- s/cout change only on a completion edge; they are stable in IDLE and during SHIFT.
- Arithmetic: {cout, s} = a + b + cin, modulo 2^(W+1); no saturation.
- rst mid-SHIFT: aborts immediately to reset values. No done is produced, and previous s/cout are cleared.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0), registered alongside s.
  - ovf = carry into the MSB XOR carry out of the MSB, i.e. signed two's-complement overflow.
  - Captured at the completion edge.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include: state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2; counter width as clog2(W).
- One natural sub-module: full_adder_cell. Combinational; inputs x, y, ci; outputs sum, co. Instantiated once in the SHIFT datapath.

Test Plan (W=4):
- a=5, b=3, cin=0, pulse start -> done exactly 4 edges later; s=8, cout=0; busy high for 4 cycles.
- a=15, b=1, cin=0 -> s=0, cout=1; then a=9, b=6, cin=1 -> s=0, cout=1.
- Start accepted with a=2, b=2; re-pulse start with a=7, b=7 during SHIFT -> ignored; s=4; only one done pulse.
- Start held high through DONE, with a=1, b=1 then a=3, b=4 on the DONE cycle -> first result s=2, second s=7; back-to-back with no IDLE cycle.
- Assert rst two cycles into SHIFT -> busy/done/s/cout=0 immediately (asynchronous); no done afterwards; a fresh start works normally.
- SERIAL_ADDER_OVF_EN defined: a=7, b=1 -> s=8, ovf=1; a=8, b=8 -> s=0, cout=1, ovf=1; a=3, b=2 -> ovf=0.
